// File: rtl/mem_arbiter_ctrl.sv
// Shared main-memory sequencer: arbitrates I-fill, D-fill and D write-through stores,
// issues burst reads, steers returned words into the owning cache and pulses completion.
module mem_arbiter_ctrl #(
    parameter int MEM_LATENCY = 4,
    parameter int BURST_LEN   = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         I_miss_req,
    input  logic [ADDR_W-1:0]            I_miss_addr,
    input  logic                         D_miss_req,
    input  logic [ADDR_W-1:0]            D_miss_addr,
    input  logic                         D_wr_req,
    input  logic [ADDR_W-1:0]            D_wr_addr,
    input  logic [15:0]                  D_wr_data,
    input  logic [15:0]                  mem_data_out,
    input  logic                         mem_data_valid,
    output logic                         mem_enable,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [15:0]                  mem_data_in,
    output logic                         I_grant,
    output logic                         D_grant,
    output logic [15:0]                  fill_data,
    output logic [$clog2(BURST_LEN)-1:0] fill_word_idx,
    output logic                         I_fill_we,
    output logic                         D_fill_we,
    output logic                         I_fill_done,
    output logic                         D_fill_done,
    output logic                         wr_done
);

    localparam int IDX_W  = $clog2(BURST_LEN);
    localparam int CNT_W  = IDX_W + 1;
    localparam int WAIT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << (IDX_W + 1)) - 1);

    typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, WRITE, DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    issue_q;
    logic [CNT_W-1:0]    recv_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                mem_en_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_din_q;
    logic                i_grant_q;
    logic                d_grant_q;
    logic                i_done_q;
    logic                d_done_q;
    logic                wr_done_q;
    logic                fill_active;

    // Word address inside the block: offset bits replaced, so the add never carries out.
    function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] a,
                                                     input logic [IDX_W-1:0]  idx);
        return (a & ~BLK_MASK) | (ADDR_W'(idx) << 1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            issue_q    <= '0;
            recv_q     <= '0;
            wait_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            i_grant_q  <= 1'b0;
            d_grant_q  <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (D_wr_req) begin
                        state_q    <= WRITE;
                        addr_q     <= D_wr_addr;
                        d_grant_q  <= 1'b1;
                        wait_q     <= '0;
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= D_wr_addr;
                        mem_din_q  <= D_wr_data;
                    end else if (D_miss_req) begin
                        state_q    <= FILL_D;
                        addr_q     <= D_miss_addr;
                        d_grant_q  <= 1'b1;
                        issue_q    <= CNT_W'(1);
                        recv_q     <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= burst_addr(D_miss_addr, '0);
                    end else if (I_miss_req) begin
                        state_q    <= FILL_I;
                        addr_q     <= I_miss_addr;
                        i_grant_q  <= 1'b1;
                        issue_q    <= CNT_W'(1);
                        recv_q     <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= burst_addr(I_miss_addr, '0);
                    end
                end
                FILL_I, FILL_D: begin
                    // Word 0 went out on the grant edge, so issue_q already counts issued words.
                    if (issue_q < CNT_W'(BURST_LEN)) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= burst_addr(addr_q, issue_q[IDX_W-1:0]);
                        issue_q    <= issue_q + 1'b1;
                    end
                    if (mem_data_valid) begin
                        recv_q <= recv_q + 1'b1;
                        if (recv_q == CNT_W'(BURST_LEN - 1)) begin
                            state_q  <= DONE;
                            i_done_q <= (state_q == FILL_I);
                            d_done_q <= (state_q == FILL_D);
                        end
                    end
                end
                WRITE: begin
                    if (wait_q == WAIT_W'(MEM_LATENCY)) begin
                        state_q   <= DONE;
                        wr_done_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    i_grant_q <= 1'b0;
                    d_grant_q <= 1'b0;
                    i_done_q  <= 1'b0;
                    d_done_q  <= 1'b0;
                    wr_done_q <= 1'b0;
                    issue_q   <= '0;
                    recv_q    <= '0;
                    wait_q    <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Returned words are steered in the cycle they arrive; valid outside a fill is dropped.
    assign fill_active   = mem_data_valid && (state_q == FILL_I || state_q == FILL_D);
    assign I_fill_we     = mem_data_valid && (state_q == FILL_I);
    assign D_fill_we     = mem_data_valid && (state_q == FILL_D);
    assign fill_data     = fill_active ? mem_data_out : '0;
    assign fill_word_idx = fill_active ? recv_q[IDX_W-1:0] : '0;

    assign mem_enable  = mem_en_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_din_q;
    assign I_grant     = i_grant_q;
    assign D_grant     = d_grant_q;
    assign I_fill_done = i_done_q;
    assign D_fill_done = d_done_q;
    assign wr_done     = wr_done_q;

endmodule
